// File: rtl/nonce_collector.sv
// Collects miner nonce hits into a small FIFO tagged with the current job id.
// Hits are blanked for SETTLE cycles after reset/new_work so stale pipeline results are not reported.
module nonce_collector #(
   parameter int DEPTH  = 8,
   parameter int SETTLE = 400,
   parameter int JOB_W  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     nonce_found,
   input  logic [31:0]              nonce_out,
   input  logic                     new_work,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [31:0]              rd_nonce,
   output logic [JOB_W-1:0]         rd_job,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     blanking,
   output logic                     overflow,
   output logic [15:0]              drop_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int SW = $clog2(SETTLE + 1);
   localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);
   localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);

   logic [31:0]      mem_nonce [DEPTH];
   logic [JOB_W-1:0] mem_job   [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [SW-1:0]    settle_cnt;
   logic [JOB_W-1:0] job_id;

   logic full;
   logic hit_live;
   logic pop;
   logic push;
   logic drop;

   assign full     = (count == FULL_CNT);
   assign blanking = (settle_cnt != '0);
   assign rd_valid = (count != '0);
   assign hit_live = nonce_found && !blanking && !new_work;
   // new_work flushes the queue, so a handshake in that cycle must not move the read pointer
   assign pop      = rd_valid && rd_ready && !new_work;
   assign push     = hit_live && (!full || pop);
   assign drop     = hit_live && full && !pop;

   // Head is masked while empty so the outputs read zero after reset and flush
   assign rd_nonce = rd_valid ? mem_nonce[rd_ptr] : '0;
   assign rd_job   = rd_valid ? mem_job[rd_ptr]   : '0;

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_nonce[wr_ptr] <= nonce_out;
         mem_job[wr_ptr]   <= job_id;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         settle_cnt <= SETTLE_LD;
         job_id     <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (new_work) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         settle_cnt <= SETTLE_LD;
         job_id     <= job_id + 1'b1;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (settle_cnt != '0)
            settle_cnt <= settle_cnt - 1'b1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF)
               drop_count <= drop_count + 1'b1;
         end
      end
   end

endmodule
